// File: rtl/flash_loader.sv
// flash_loader: copies LENGTH bytes from a flash reader into RAM.
//
// Each byte is one flash transaction followed by one RAM write. A flash
// transaction is requested by raising flash_cs. The reader answers by
// raising flash_busy, and the data in flash_dout is valid once busy falls.
// If busy never rises, the request is dropped after TIMEOUT cycles. A
// 3-cycle low gap follows so the reader's synchroniser sees a clean edge,
// and then the same address is requested again.
//
// RAM handshake: ram_we is raised together with stable ram_addr/ram_data.
// All three hold until a cycle in which ram_we and ram_ack are both high.
// That cycle is the transfer, and ram_we drops on the next edge. ram_ack
// has no meaning while ram_we is low.
//
// dbg_state_o exposes the FSM state register for debug and checkers.
module flash_loader #(
    parameter logic [23:0] FLASH_BASE = 24'h200000,
    parameter logic [15:0] RAM_BASE   = 16'h0000,
    parameter logic [16:0] LENGTH     = 17'd32768,
    parameter logic [4:0]  TIMEOUT    = 5'd16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        flash_ready,
    input  logic        flash_busy,
    input  logic [7:0]  flash_dout,
    output logic [23:0] flash_addr,
    output logic        flash_cs,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_data,
    output logic        ram_we,
    input  logic        ram_ack,
    output logic        active,
    output logic        done,
    output logic [7:0]  checksum,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_REQ      = 3'd2,
        S_WAIT_HI  = 3'd3,
        S_WAIT_LO  = 3'd4,
        S_WRITE    = 3'd5,
        S_GAP      = 3'd6,
        S_FINISH   = 3'd7
    } state_t;

    state_t      state_q, state_d;
    // 17 bits so that a full 65536-byte run can reach its terminal count
    logic [16:0] count_q, count_d;
    // Shared counter: request timeout in WAIT_HI, low-gap length in GAP
    logic [4:0]  tmo_q, tmo_d;
    logic [23:0] flash_addr_q, flash_addr_d;
    logic        cs_q, cs_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic [7:0]  ram_data_q, ram_data_d;
    logic        we_q, we_d;
    logic        active_q, active_d;
    logic        done_q, done_d;
    logic [7:0]  csum_q, csum_d;
    logic [16:0] count_inc;

    assign count_inc = count_q + 17'd1;

    // State and datapath registers, cleared asynchronously by resetn
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            tmo_q        <= '0;
            flash_addr_q <= '0;
            cs_q         <= 1'b0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            we_q         <= 1'b0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
            csum_q       <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            tmo_q        <= tmo_d;
            flash_addr_q <= flash_addr_d;
            cs_q         <= cs_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            we_q         <= we_d;
            active_q     <= active_d;
            done_q       <= done_d;
            csum_q       <= csum_d;
        end
    end

    // Next-state and register-update logic; every register holds unless a state changes it
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        tmo_d        = tmo_q;
        flash_addr_d = flash_addr_q;
        cs_d         = cs_q;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        we_d         = we_q;
        active_d     = active_q;
        done_d       = done_q;
        csum_d       = csum_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d   = 1'b0;
                    csum_d   = '0;
                    count_d  = '0;
                    active_d = 1'b1;
                    state_d  = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (flash_ready && !flash_busy) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                flash_addr_d = FLASH_BASE + {7'd0, count_q};
                cs_d         = 1'b1;
                tmo_d        = '0;
                state_d      = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (flash_busy) begin
                    cs_d    = 1'b0;
                    state_d = S_WAIT_LO;
                end else if (tmo_q == TIMEOUT - 5'd1) begin
                    // Reader missed the request: back off, then re-request the same address
                    cs_d    = 1'b0;
                    tmo_d   = '0;
                    state_d = S_GAP;
                end else begin
                    tmo_d = tmo_q + 5'd1;
                end
            end
            S_GAP: begin
                if (tmo_q == 5'd2) begin
                    state_d = S_REQ;
                end else begin
                    tmo_d = tmo_q + 5'd1;
                end
            end
            S_WAIT_LO: begin
                if (!flash_busy) begin
                    ram_data_d = flash_dout;
                    ram_addr_d = RAM_BASE + count_q[15:0];
                    we_d       = 1'b1;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                if (we_q && ram_ack) begin
                    we_d    = 1'b0;
                    csum_d  = csum_q ^ ram_data_q;
                    count_d = count_inc;
                    state_d = (count_inc == LENGTH) ? S_FINISH : S_REQ;
                end
            end
            S_FINISH: begin
                done_d   = 1'b1;
                active_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign flash_addr  = flash_addr_q;
    assign flash_cs    = cs_q;
    assign ram_addr    = ram_addr_q;
    assign ram_data    = ram_data_q;
    assign ram_we      = we_q;
    assign active      = active_q;
    assign done        = done_q;
    assign checksum    = csum_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_flash_loader.sv
// tb_flash_loader: randomized bench for flash_loader with a reactive flash
// reader model, a RAM acknowledge driver, and a scoreboard. The scoreboard
// holds the expected RAM writes of each run as {ram_addr, ram_data}.
module tb_flash_loader;

    localparam logic [23:0] FB  = 24'h200000;
    localparam logic [15:0] RB  = 16'hFFFE;   // exercises 16-bit RAM address wrap
    localparam int          LEN = 4;
    localparam int          TMO = 16;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        flash_ready = 1'b0;
    logic        flash_busy = 1'b0;
    logic [7:0]  flash_dout = 8'h00;
    logic        ram_ack = 1'b0;
    logic [23:0] flash_addr;
    logic        flash_cs;
    logic [15:0] ram_addr;
    logic [7:0]  ram_data;
    logic        ram_we;
    logic        active;
    logic        done;
    logic [7:0]  checksum;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    flash_loader #(
        .FLASH_BASE(FB),
        .RAM_BASE  (RB),
        .LENGTH    (17'(LEN)),
        .TIMEOUT   (5'(TMO))
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .flash_ready(flash_ready),
        .flash_busy (flash_busy),
        .flash_dout (flash_dout),
        .flash_addr (flash_addr),
        .flash_cs   (flash_cs),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_we     (ram_we),
        .ram_ack    (ram_ack),
        .active     (active),
        .done       (done),
        .checksum   (checksum),
        .dbg_state_o(dbg_state)
    );

    // ---------------- shared bench state ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [23:0] exp_q[$];
    logic [7:0]  mem [LEN];
    logic [7:0]  exp_csum;
    int          run_base = 0;     // wr_total at the start of the current run
    int          wr_total = 0;     // monitor: RAM writes observed
    int          cs_rises = 0;     // monitor: flash requests observed
    int          f_rises = 0;      // flash model: requests seen
    int          ignore_at = -1;   // flash model ignores request with this index
    bit          last_ignored = 1'b0;
    int          busy_fixed = 20;  // 0 = random busy length
    int          ack_delay = 0;    // 0 = ram_ack tied high
    bit          ready_noise = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- flash reader model ----------------
    initial begin : flash_model
        logic f_prev;
        int   f_wait, f_left, f_idx;
        f_prev = 1'b0; f_wait = 0; f_left = 0; f_idx = 0;
        forever begin
            @(posedge clk); #1;
            if (!resetn) begin
                flash_busy = 1'b0;
                f_prev = 1'b0; f_wait = 0; f_left = 0;
            end else begin
                if (f_wait > 0) begin
                    f_wait--;
                    if (f_wait == 0) begin
                        flash_busy = 1'b1;
                        f_left = (busy_fixed > 0) ? busy_fixed : $urandom_range(1, 20);
                        flash_dout = 8'($urandom);
                    end
                end else if (f_left > 0) begin
                    f_left--;
                    if (f_left == 0) begin
                        flash_busy = 1'b0;
                        flash_dout = (f_idx >= 0 && f_idx < LEN) ? mem[f_idx] : 8'hEE;
                    end else begin
                        flash_dout = 8'($urandom);
                    end
                end
                if (flash_cs && !f_prev) begin
                    if (f_rises == ignore_at) begin
                        last_ignored = 1'b1;
                    end else begin
                        last_ignored = 1'b0;
                        f_idx  = int'(flash_addr - FB);
                        f_wait = $urandom_range(1, 4);
                    end
                    f_rises++;
                end
                f_prev = flash_cs;
            end
        end
    end

    // ---------------- RAM acknowledge driver ----------------
    initial begin : ack_drv
        int we_cnt;
        we_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (ack_delay == 0) begin
                ram_ack = 1'b1;
            end else if (ram_we) begin
                we_cnt++;
                ram_ack = (we_cnt >= ack_delay);
            end else begin
                we_cnt = 0;
                ram_ack = 1'($urandom_range(0, 1));   // noise outside a write
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic        p_cs, p_we;
        logic [15:0] h_addr;
        logic [7:0]  h_data;
        logic [23:0] item;
        int          hi_len, lo_len;
        p_cs = 1'b0; p_we = 1'b0; h_addr = '0; h_data = '0; hi_len = 0; lo_len = 100;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                p_cs = 1'b0; p_we = 1'b0; hi_len = 0; lo_len = 100;
            end else begin
                if (flash_cs && !p_cs) begin
                    cs_rises++;
                    check("cs_low_gap_ge3", 32'(lo_len >= 3), 32'd1);
                    check("req_addr", 32'(flash_addr), 32'(FB + 24'(wr_total - run_base)));
                    check("req_while_we", 32'(ram_we), 32'd0);
                    hi_len = 0;
                end
                if (!flash_cs && p_cs) begin
                    if (last_ignored) check("timeout_cs_high", 32'(hi_len), 32'(TMO));
                    lo_len = 0;
                end
                if (flash_cs) hi_len++; else lo_len++;
                if (ram_we && p_we) begin
                    check("we_addr_hold", 32'(ram_addr), 32'(h_addr));
                    check("we_data_hold", 32'(ram_data), 32'(h_data));
                end
                if (ram_we && ram_ack) begin
                    check("write_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        item = exp_q.pop_front();
                        check("write_addr_data", 32'({ram_addr, ram_data}), 32'(item));
                    end
                    wr_total++;
                end
                p_cs = flash_cs; p_we = ram_we; h_addr = ram_addr; h_data = ram_data;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start();
        @(posedge clk); #1;
        exp_q.delete();
        exp_csum = 8'h00;
        for (int i = 0; i < LEN; i++) begin
            exp_q.push_back({RB + 16'(i), mem[i]});
            exp_csum ^= mem[i];
        end
        run_base = wr_total;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_active", 32'(active), 32'd1);
        check("start_done_clr", 32'(done), 32'd0);
        check("start_csum_clr", 32'(checksum), 32'd0);
    endtask

    task automatic wait_done_and_check();
        int cyc;
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (ready_noise) flash_ready = ($urandom_range(0, 3) != 0);
        end
        flash_ready = 1'b1;
        check("done_in_time", 32'(done), 32'd1);
        check("end_active", 32'(active), 32'd0);
        check("end_checksum", 32'(checksum), 32'(exp_csum));
        check("end_writes", 32'(wr_total - run_base), 32'(LEN));
        check("end_exp_left", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("done_sticky", 32'(done), 32'd1);
        check("idle_no_we", 32'(ram_we), 32'd0);
    endtask

    task automatic random_mem();
        for (int i = 0; i < LEN; i++) mem[i] = 8'($urandom);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int cyc, rises0, wr0;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", 32'(flash_cs), 32'd0);
        check("rst_faddr", 32'(flash_addr), 32'd0);
        check("rst_we", 32'(ram_we), 32'd0);
        check("rst_raddr", 32'(ram_addr), 32'd0);
        check("rst_rdata", 32'(ram_data), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_csum", 32'(checksum), 32'd0);
        resetn = 1'b1;
        flash_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_active", 32'(active), 32'd0);

        // basic copy with fixed data, busy 20, ack tied high
        mem[0] = 8'hA5; mem[1] = 8'h5A; mem[2] = 8'hFF; mem[3] = 8'h00;
        busy_fixed = 20; ack_delay = 0;
        do_start();
        wait_done_and_check();
        check("basic_checksum_00", 32'(checksum), 32'h00);

        // flash_ready held low for 40 cycles after start
        random_mem();
        busy_fixed = 0;
        flash_ready = 1'b0;
        rises0 = cs_rises;
        do_start();
        repeat (40) @(posedge clk);
        #1;
        check("notready_no_req", 32'(cs_rises - rises0), 32'd0);
        check("notready_cs_low", 32'(flash_cs), 32'd0);
        flash_ready = 1'b1;
        wait_done_and_check();

        // first request ignored: timeout, gap, retry of the same address
        random_mem();
        rises0 = cs_rises;
        ignore_at = f_rises;
        do_start();
        wait_done_and_check();
        check("retry_req_count", 32'(cs_rises - rises0), 32'(LEN + 1));
        ignore_at = -1;

        // ram_ack delayed 5 cycles per write
        random_mem();
        ack_delay = 5;
        do_start();
        wait_done_and_check();
        ack_delay = 0;

        // reset during the third byte's busy-low wait
        random_mem();
        busy_fixed = 20;
        do_start();
        cyc = 0;
        while (!((wr_total - run_base) == 2 && flash_busy && !flash_cs) && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rst_run_reached_byte3", 32'(wr_total - run_base), 32'd2);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_cs", 32'(flash_cs), 32'd0);
        check("midrst_faddr", 32'(flash_addr), 32'd0);
        check("midrst_we", 32'(ram_we), 32'd0);
        check("midrst_raddr", 32'(ram_addr), 32'd0);
        check("midrst_rdata", 32'(ram_data), 32'd0);
        check("midrst_active", 32'(active), 32'd0);
        check("midrst_csum", 32'(checksum), 32'd0);
        exp_q.delete();
        wr0 = wr_total;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("post_rst_no_write", 32'(wr_total - wr0), 32'd0);
        check("post_rst_idle", 32'(active), 32'd0);
        do_start();
        wait_done_and_check();

        // start pulses while a run is active are ignored
        random_mem();
        busy_fixed = 0;
        do_start();
        cyc = 0;
        while ((wr_total - run_base) < 1 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        for (int k = 0; k < 2; k++) begin
            if (active) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
            repeat (4) @(posedge clk);
            #1;
        end
        wait_done_and_check();

        // randomized runs
        for (int r = 0; r < 10; r++) begin
            random_mem();
            busy_fixed  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            ack_delay   = $urandom_range(0, 6);
            ready_noise = 1'($urandom_range(0, 1));
            ignore_at   = ($urandom_range(0, 2) == 0) ? f_rises + $urandom_range(0, LEN - 1) : -1;
            do_start();
            wait_done_and_check();
            ready_noise = 1'b0;
        end
        ignore_at = -1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
